// File: rtl/serdes_pkg.sv
// Shared definitions for the serializer/deserializer pair.
// Provides:
//   DefaultWidth       - word width shared with the SIPO side
//   LsbFirst, MsbFirst - bit-order selectors
//   StIdle, StShift    - serializer FSM state encodings
package serdes_pkg;

  localparam int unsigned DefaultWidth = 4;

  localparam bit LsbFirst = 1'b0;
  localparam bit MsbFirst = 1'b1;

  // Plain constants instead of an enum so legacy tools can consume the encoding.
  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StShift = 1'b1;

endpackage

// File: rtl/serdes_hold_reg.sv
// One-entry holding (skid) register with full flag.
// Ports:
//   clk     - clock, rising edge
//   reset   - asynchronous active-high reset (clears data and full)
//   wr      - capture wdata and set full
//   wdata   - word to capture
//   consume - release the held word (clears full)
//   rdata   - held word
//   full    - a word is held
module serdes_hold_reg
  import serdes_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             consume,
  output logic [WIDTH-1:0] rdata,
  output logic             full
);

  logic [WIDTH-1:0] data_q;
  logic             full_q;

  // A write wins over a consume; the owner only writes while empty, so the
  // two never legitimately coincide on a held word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else if (wr) begin
      data_q <= wdata;
      full_q <= 1'b1;
    end else if (consume) begin
      full_q <= 1'b0;
    end
  end

  assign rdata = data_q;
  assign full  = full_q;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer feeding the SIPO shift chain.
// Words arrive over a valid/ready handshake and leave one bit per clock, with
// first/last frame strobes. A one-entry holding register lets back-to-back
// words stream without an idle bit between them.
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-high reset
//   din        - parallel word from the producer
//   din_valid  - din holds a word
//   din_ready  - a word can be accepted this cycle
//   sout       - serial data bit
//   sout_valid - sout carries a valid bit
//   sout_first - sout is the first bit of a word
//   sout_last  - sout is the last bit of a word
//   busy       - shifting, or a word is waiting in the holding register
module piso_serializer
  import serdes_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter bit          MSB_FIRST = LsbFirst
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_first,
  output logic             sout_last,
  output logic             busy
);

  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]  bitcnt_q, bitcnt_d;

  logic             hold_full;
  logic [WIDTH-1:0] hold_data;
  logic             hold_wr;
  logic             hold_consume;

  logic accept;
  logic load;
  logic bypass;
  logic last_bit;

  assign last_bit  = (state_q == StShift) && (bitcnt_q == LastCnt);
  assign din_ready = !hold_full && !reset;
  assign accept    = din_valid && din_ready;

  // Load point: idle, or the cycle the final bit of a word is on sout.
  assign load = (state_q == StIdle) || last_bit;

  // Hold has priority over a fresh word; din goes straight into the shifter
  // only when hold is empty at a load point.
  assign bypass       = load && !hold_full && accept;
  assign hold_wr      = accept && !bypass;
  assign hold_consume = load && hold_full;

  serdes_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk    (clk),
    .reset  (reset),
    .wr     (hold_wr),
    .wdata  (din),
    .consume(hold_consume),
    .rdata  (hold_data),
    .full   (hold_full)
  );

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    if (load) begin
      if (hold_full) begin
        shreg_d  = hold_data;
        bitcnt_d = '0;
        state_d  = StShift;
      end else if (accept) begin
        shreg_d  = din;
        bitcnt_d = '0;
        state_d  = StShift;
      end else begin
        state_d = StIdle;
      end
    end else begin
      // Mid-word: move the next bit toward the output end.
      if (MSB_FIRST == MsbFirst) begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
      end else begin
        shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
      end
      bitcnt_d = bitcnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      shreg_q  <= '0;
      bitcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
    end
  end

  // Outputs come from registers only; no combinational path from din.
  assign sout       = (MSB_FIRST == MsbFirst) ? shreg_q[WIDTH-1] : shreg_q[0];
  assign sout_valid = (state_q == StShift);
  assign sout_first = (state_q == StShift) && (bitcnt_q == '0);
  assign sout_last  = last_bit;
  assign busy       = (state_q == StShift) || hold_full;

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] dv = '0;
  logic [3:0] din4 = '0;
  logic [7:0] din8 = '0;
  logic [2:0] rdy, so, sv, sf, sl, bz;

  always #5 clk = ~clk;

  // DUT 0: WIDTH=4 LSB-first, DUT 1: WIDTH=4 MSB-first, DUT 2: WIDTH=8 LSB-first.
  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .din(din4), .din_valid(dv[0]), .din_ready(rdy[0]),
    .sout(so[0]), .sout_valid(sv[0]), .sout_first(sf[0]), .sout_last(sl[0]), .busy(bz[0])
  );
  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .din(din4), .din_valid(dv[1]), .din_ready(rdy[1]),
    .sout(so[1]), .sout_valid(sv[1]), .sout_first(sf[1]), .sout_last(sl[1]), .busy(bz[1])
  );
  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut2 (
    .clk(clk), .reset(reset), .din(din8), .din_valid(dv[2]), .din_ready(rdy[2]),
    .sout(so[2]), .sout_valid(sv[2]), .sout_first(sf[2]), .sout_last(sl[2]), .busy(bz[2])
  );

  int checks = 0;
  int passes = 0;

  // Reference model: the serial stream as a queue of {bit, first, last}.
  // Each accepted word appends its bits; one entry is presented per cycle.
  int         sel = 0;
  int         w = 4;
  bit         msb = 1'b0;
  logic [2:0] q[$];
  logic [2:0] cur = '0;
  bit         cur_valid = 1'b0;

  logic [31:0] rec;
  int          nbits, nfirst, nlast;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) passes = passes + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_sel(input int s);
    sel = s;
    w   = (s == 2) ? 8 : 4;
    msb = (s == 1);
  endtask

  function automatic void push_word(input logic [7:0] word);
    for (int i = 0; i < w; i++) begin
      int idx;
      idx = msb ? (w - 1 - i) : i;
      q.push_back({word[idx], 1'(i == 0), 1'(i == w - 1)});
    end
  endfunction

  task automatic clear_rec();
    rec = '0; nbits = 0; nfirst = 0; nlast = 0;
  endtask

  // One clock: drive at the falling edge, check there, update model at the rising edge.
  task automatic cycle(input bit v, input logic [7:0] d);
    bit exp_ready;
    bit acc;
    @(negedge clk);
    dv      = '0;
    dv[sel] = v;
    din4    = d[3:0];
    din8    = d;
    exp_ready = !reset && (q.size() < w);
    chk("din_ready", 32'(rdy[sel]), 32'(exp_ready));
    chk("sout_valid", 32'(sv[sel]), 32'(cur_valid));
    chk("sout_first", 32'(sf[sel]), 32'(cur_valid && cur[1]));
    chk("sout_last", 32'(sl[sel]), 32'(cur_valid && cur[0]));
    chk("busy", 32'(bz[sel]), 32'(cur_valid || (q.size() >= w)));
    if (cur_valid) chk("sout", 32'(so[sel]), 32'(cur[2]));
    if (sv[sel]) begin
      rec   = {rec[30:0], so[sel]};
      nbits = nbits + 1;
    end
    if (sf[sel]) nfirst = nfirst + 1;
    if (sl[sel]) nlast = nlast + 1;
    acc = v && exp_ready;
    @(posedge clk);
    if (acc) push_word(d);
    if (q.size() > 0) begin
      cur       = q.pop_front();
      cur_valid = 1'b1;
    end else begin
      cur_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 8'h00);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_sout"}, 32'(so), 32'd0);
    chk({tag, "_valid"}, 32'(sv), 32'd0);
    chk({tag, "_first"}, 32'(sf), 32'd0);
    chk({tag, "_last"}, 32'(sl), 32'd0);
    chk({tag, "_busy"}, 32'(bz), 32'd0);
    chk({tag, "_ready"}, 32'(rdy), 32'd0);
  endtask

  // Called just after a rising edge: reset lands between edges.
  task automatic async_reset();
    #2;
    reset = 1'b1;
    dv    = '0;
    #1;
    reset_checks("async_rst");
    q.delete();
    cur_valid = 1'b0;
    @(negedge clk);
    reset_checks("rst_hold");
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", 32'(rdy), 32'b111);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    set_sel(0);
    @(negedge clk);
    reset_checks("por");
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("ready_after_por", 32'(rdy), 32'b111);

    // Single word 4'h6, LSB first.
    clear_rec();
    cycle(1'b1, 8'h06);
    idle(5);
    chk("w6_bits", rec[3:0], 32'b0110);
    chk("w6_nbits", 32'(nbits), 32'd4);
    chk("w6_first_last", {nfirst[15:0], nlast[15:0]}, {16'd1, 16'd1});

    // Back-to-back 4'h6 then 4'h9 via the holding register.
    clear_rec();
    cycle(1'b1, 8'h06);
    cycle(1'b1, 8'h09);
    idle(9);
    chk("b2b_bits", rec[7:0], 32'b0110_1001);
    chk("b2b_nbits", 32'(nbits), 32'd8);
    chk("b2b_first", 32'(nfirst), 32'd2);

    // din_valid held with 4'h3 while hold is full: no overwrite, accepted once.
    clear_rec();
    cycle(1'b1, 8'h06);
    cycle(1'b1, 8'h09);
    repeat (4) cycle(1'b1, 8'h03);
    idle(12);
    chk("hold_bits", rec[11:0], 32'b0110_1001_1100);
    chk("hold_nbits", 32'(nbits), 32'd12);

    // Bit order for 4'hC.
    set_sel(1);
    clear_rec();
    cycle(1'b1, 8'h0C);
    idle(5);
    chk("msb_c", rec[3:0], 32'b1100);
    set_sel(0);
    clear_rec();
    cycle(1'b1, 8'h0C);
    idle(5);
    chk("lsb_c", rec[3:0], 32'b0011);

    // Reset during bit 2 of 4'hA, then a clean 4'h5.
    cycle(1'b1, 8'h0A);
    idle(2);
    async_reset();
    clear_rec();
    cycle(1'b1, 8'h05);
    idle(5);
    chk("post_rst_bits", rec[3:0], 32'b1010);
    chk("post_rst_first_last", {nfirst[15:0], nlast[15:0]}, {16'd1, 16'd1});

    // WIDTH=8, 8'hA5 LSB first.
    set_sel(2);
    clear_rec();
    cycle(1'b1, 8'hA5);
    idle(9);
    chk("w8_bits", rec[7:0], 32'b1010_0101);
    chk("w8_last", 32'(nlast), 32'd1);

    // Randomized traffic on each configuration against the stream model.
    for (int s = 0; s < 3; s++) begin
      set_sel(s);
      repeat (150) cycle($urandom_range(0, 3) != 0, 8'($urandom));
      async_reset();
      repeat (100) cycle($urandom_range(0, 1) != 0, 8'($urandom));
      idle(12);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
